// File: rtl/stack_tos_unit.sv
// stack_tos_unit: operand stack with the top word cached in a register and lower words in a sync-read RAM.
// Optional high-water tracking enabled by defining STACK_TOS_UNIT_HWM_EN.
module stack_tos_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [DATA_WIDTH-1:0] top,
  output logic [ADDR_WIDTH:0]   depth,
  output logic                  empty,
  output logic                  full,
  output logic                  err_ovf,
  output logic                  err_unf,
  output logic                  err_ill,
  output logic [ADDR_WIDTH:0]   high_water
);
  localparam logic [ADDR_WIDTH:0]   CAP   = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0]   ONE_D = 1;
  localparam logic [ADDR_WIDTH:0]   TWO_D = 2;
  localparam logic [ADDR_WIDTH-1:0] ONE_A = 1;
  typedef enum logic [1:0] {IDLE, REFILL, SWAP2} state_t;
  state_t                state_q;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH-1];
  logic [DATA_WIDTH-1:0] top_q, rsp_data_q, rd_q;
  logic [ADDR_WIDTH:0]   depth_q, depth_d;
  logic [ADDR_WIDTH-1:0] sp, sp_lo, waddr;
  logic rsp_valid_q, err_ovf_q, err_unf_q, err_ill_q;
  logic acc, op_push, op_pop, op_dup, op_swap, op_clr, op_ill;
  logic push_ok, pop_ok, dup_ok, swap_ok, we, re;
  assign acc     = cmd_valid && state_q == IDLE;
  assign op_push = acc && cmd_op == 3'd1;
  assign op_pop  = acc && cmd_op == 3'd2;
  assign op_dup  = acc && cmd_op == 3'd3;
  assign op_swap = acc && cmd_op == 3'd4;
  assign op_clr  = acc && cmd_op == 3'd5;
  assign op_ill  = acc && cmd_op[2:1] == 2'b11;
  assign push_ok = op_push && !full;
  assign dup_ok  = op_dup && !empty && !full;
  assign pop_ok  = op_pop && !empty;
  assign swap_ok = op_swap && depth_q >= TWO_D;
  assign sp      = depth_q[ADDR_WIDTH-1:0] - ONE_A;
  assign sp_lo   = sp - ONE_A;
  // SWAP2 writes the old TOS into the slot it just read from
  assign we      = !reset && ((push_ok && !empty) || dup_ok || state_q == SWAP2);
  assign waddr   = state_q == SWAP2 ? sp_lo : sp;
  assign re      = (pop_ok && depth_q >= TWO_D) || swap_ok;
  assign depth_d = (push_ok || dup_ok) ? depth_q + ONE_D : pop_ok ? depth_q - ONE_D : op_clr ? '0 : depth_q;
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= top_q;
    if (re) rd_q <= mem[sp_lo];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      depth_q     <= '0;
      top_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
      err_ill_q   <= 1'b0;
    end else begin
      depth_q     <= depth_d;
      rsp_valid_q <= pop_ok;
      if (pop_ok) rsp_data_q <= top_q;
      if (state_q != IDLE) begin
        top_q   <= rd_q;
        state_q <= IDLE;
      end else begin
        if (push_ok) top_q <= cmd_data;
        if ((pop_ok && depth_q == ONE_D) || op_clr) top_q <= '0;
        if (re) state_q <= pop_ok ? REFILL : SWAP2;
      end
      err_ovf_q <= !op_clr && (err_ovf_q || ((op_push || op_dup) && full));
      err_unf_q <= !op_clr && (err_unf_q || ((op_pop || op_dup) && empty) || (op_swap && depth_q < TWO_D));
      err_ill_q <= !op_clr && (err_ill_q || op_ill);
    end
  end
`ifdef STACK_TOS_UNIT_HWM_EN
  logic [ADDR_WIDTH:0] hwm_q;
  always_ff @(posedge clk) hwm_q <= reset ? '0 : (depth_d > hwm_q ? depth_d : hwm_q);
  assign high_water = hwm_q;
`else
  assign high_water = '0;
`endif
  assign cmd_ready = state_q == IDLE;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign top       = top_q;
  assign depth     = depth_q;
  assign empty     = depth_q == '0;
  assign full      = depth_q == CAP;
  assign err_ovf   = err_ovf_q;
  assign err_unf   = err_unf_q;
  assign err_ill   = err_ill_q;
endmodule

// File: tb/tb_stack_tos_unit.sv
// tb_stack_tos_unit: directed and random command streams checked against a queue-based stack model.
module tb_stack_tos_unit;
  localparam int CAP = 16;
  logic clk = 0, reset = 1, cmd_valid = 0, cmd_ready, rsp_valid, empty, full, err_ovf, err_unf, err_ill;
  logic [2:0] cmd_op = 0;
  logic [7:0] cmd_data = 0, rsp_data, top;
  logic [4:0] depth, high_water;
  int checks = 0, errors = 0;
  logic [7:0] stk[$];
  logic m_ovf, m_unf, m_ill;
  int m_hwm;
  always #5 clk = ~clk;
  stack_tos_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .top(top), .depth(depth),
    .empty(empty), .full(full), .err_ovf(err_ovf), .err_unf(err_unf), .err_ill(err_ill),
    .high_water(high_water));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    stk.delete();
    m_ovf = 0; m_unf = 0; m_ill = 0; m_hwm = 0;
  endtask
  task automatic do_reset();
    reset = 1; cmd_valid = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    model_reset();
  endtask
  task automatic check_state();
    int n;
    n = stk.size();
    chk("top", top, n > 0 ? stk[n-1] : 8'h00);
    chk("depth", depth, n);
    chk("empty", empty, n == 0);
    chk("full", full, n == CAP);
    chk("err_ovf", err_ovf, m_ovf);
    chk("err_unf", err_unf, m_unf);
    chk("err_ill", err_ill, m_ill);
`ifdef STACK_TOS_UNIT_HWM_EN
    chk("high_water", high_water, m_hwm);
`else
    chk("high_water", high_water, 0);
`endif
  endtask
  task automatic do_cmd(input logic [2:0] op, input logic [7:0] d);
    int n, w;
    logic exp_rsp, busy;
    logic [7:0] exp_d, t;
    n = stk.size(); exp_rsp = 0; busy = 0; exp_d = 0;
    case (op)
      3'd1: if (n == CAP) m_ovf = 1; else stk.push_back(d);
      3'd2: if (n == 0) m_unf = 1; else begin exp_rsp = 1; busy = n >= 2; exp_d = stk.pop_back(); end
      3'd3: if (n == 0) m_unf = 1; else if (n == CAP) m_ovf = 1; else stk.push_back(stk[n-1]);
      3'd4: if (n < 2) m_unf = 1; else begin busy = 1; t = stk[n-1]; stk[n-1] = stk[n-2]; stk[n-2] = t; end
      3'd5: begin stk.delete(); m_ovf = 0; m_unf = 0; m_ill = 0; end
      3'd6, 3'd7: m_ill = 1;
      default: ;
    endcase
    if (stk.size() > m_hwm) m_hwm = stk.size();
    @(negedge clk);
    cmd_valid = 1; cmd_op = op; cmd_data = d;
    @(posedge clk);
    #1 cmd_valid = 0;
    chk("rsp_valid", rsp_valid, exp_rsp);
    if (exp_rsp) chk("rsp_data", rsp_data, exp_d);
    chk("cmd_ready", cmd_ready, !busy);
    w = 0;
    while (!cmd_ready && w < 4) begin @(posedge clk); #1; w++; end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
    if (busy) chk("rsp_after", rsp_valid, 0);
    check_state();
  endtask
  initial begin
    int r;
    do_reset();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    check_state();
    do_cmd(1, 8'h11); do_cmd(1, 8'h22); do_cmd(1, 8'h33);
    chk("t1_top", top, 8'h33);
    chk("t1_depth", depth, 3);
    do_cmd(2, 0); do_cmd(2, 0); do_cmd(2, 0);
    chk("t2_empty", empty, 1);
    do_cmd(2, 0);
    chk("t3_unf", err_unf, 1);
    do_cmd(5, 0);
    chk("t3_clr", err_unf, 0);
    for (int i = 0; i < 16; i++) do_cmd(1, 8'(i));
    chk("t4_full", full, 1);
    chk("t4_top", top, 8'd15);
    do_cmd(1, 8'hAA);
    chk("t4_ovf", err_ovf, 1);
    chk("t4_top2", top, 8'd15);
    do_cmd(3, 0);
    chk("t4_depth", depth, 16);
    do_reset();
    do_cmd(1, 8'h05); do_cmd(1, 8'h09); do_cmd(4, 0);
    chk("t5_top", top, 8'h05);
    do_cmd(2, 0); do_cmd(2, 0);
    do_cmd(1, 8'h44); do_cmd(4, 0);
    chk("t5_unf", err_unf, 1);
    chk("t5_top2", top, 8'h44);
    do_reset();
    do_cmd(1, 8'h01); do_cmd(1, 8'h02); do_cmd(1, 8'h03);
    @(negedge clk);
    cmd_valid = 1; cmd_op = 3'd2;
    @(posedge clk);
    #1 cmd_valid = 0;
    chk("t6_busy", cmd_ready, 0);
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    model_reset();
    chk("t6_ready", cmd_ready, 1);
    chk("t6_rsp", rsp_valid, 0);
    check_state();
    do_cmd(7, 0);
    chk("t6_ill", err_ill, 1);
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      do_cmd(r < 40 ? 3'd1 : r < 62 ? 3'd2 : r < 72 ? 3'd3 : r < 84 ? 3'd4 :
             r < 87 ? 3'd5 : r < 93 ? 3'd0 : (r < 96 ? 3'd6 : 3'd7), 8'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
